// File: rtl/prog_loader_ctl.sv
// prog_loader_ctl: streams a program image into memory, optionally verifies
// it with an XOR readback, then releases the core under a cycle watchdog.
module prog_loader_ctl #(
    parameter int unsigned   DW         = 32,
    parameter int unsigned   AW         = 32,
    parameter int unsigned   BASE_ADDR  = 2048,
    parameter int unsigned   DEPTH      = 256,
    parameter logic [DW-1:0] HALT_WORD  = DW'(32'hFFFF0000),
    parameter int unsigned   RD_LAT     = 1,
    parameter bit            VERIFY_EN  = 1'b1,
    parameter int unsigned   MAX_CYCLES = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DW-1:0]           s_data,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    core_rst,
    input  logic [DW-1:0]           core_instr,
    output logic                    busy,
    output logic                    done,
    output logic                    verify_err,
    output logic                    load_ovf,
    output logic                    timeout,
    output logic [$clog2(DEPTH):0]  word_cnt,
    output logic [31:0]             cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VERIFY, S_DRAIN, S_RUN, S_DONE
    } state_t;

    localparam int unsigned   CW         = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LP_BASE    = AW'(BASE_ADDR);
    localparam logic [AW-1:0] LP_STRIDE  = AW'(DW / 8);
    localparam logic [CW-1:0] LP_DEPTH   = CW'(DEPTH);
    localparam logic [31:0]   LP_WD_LAST = 32'(MAX_CYCLES - 1);

    state_t        r_state;
    logic          r_mem_we;
    logic          r_core_rst;
    logic          r_busy;
    logic          r_done;
    logic          r_verify_err;
    logic          r_load_ovf;
    logic          r_timeout;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_chk;
    logic [DW-1:0] r_rchk;
    logic [CW-1:0] r_word_cnt;
    logic [CW-1:0] r_rd_idx;
    logic [31:0]   r_cycle_cnt;
    // bit 0 marks a read address on the bus now; bit RD_LAT marks its data
    logic [RD_LAT:0] r_vld;

    logic          w_ready;
    logic          w_acc;
    logic          w_sentinel;
    logic          w_last_slot;
    logic          w_last_rd;
    logic          w_halt;
    logic          w_wd_exp;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

    assign w_ready     = (r_state == S_LOAD) && (r_word_cnt < LP_DEPTH);
    assign w_acc       = w_ready && s_valid;
    assign w_sentinel  = (s_data == HALT_WORD);
    assign w_last_slot = (r_word_cnt == LP_DEPTH - CW'(1));
    assign w_last_rd   = (r_rd_idx == r_word_cnt - CW'(1));
    assign w_halt      = (core_instr == HALT_WORD);
    assign w_wd_exp    = (r_cycle_cnt == LP_WD_LAST);
    assign w_waddr     = LP_BASE + AW'(r_word_cnt) * LP_STRIDE;
    assign w_raddr     = LP_BASE + AW'(r_rd_idx) * LP_STRIDE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= LP_BASE;
            r_mem_wdata  <= '0;
            r_core_rst   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_verify_err <= 1'b0;
            r_load_ovf   <= 1'b0;
            r_timeout    <= 1'b0;
            r_word_cnt   <= '0;
            r_rd_idx     <= '0;
            r_cycle_cnt  <= '0;
            r_chk        <= '0;
            r_rchk       <= '0;
            r_vld        <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_vld    <= {r_vld[RD_LAT-1:0], r_state == S_VERIFY};
            if (r_vld[RD_LAT]) r_rchk <= r_rchk ^ mem_rdata;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_LOAD;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_verify_err <= 1'b0;
                        r_load_ovf   <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_word_cnt   <= '0;
                        r_rd_idx     <= '0;
                        r_cycle_cnt  <= '0;
                        r_chk        <= '0;
                        r_rchk       <= '0;
                        r_mem_addr   <= LP_BASE;
                    end
                end
                S_LOAD: begin
                    if (w_acc) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_waddr;
                        r_mem_wdata <= s_data;
                        r_chk       <= r_chk ^ s_data;
                        r_word_cnt  <= r_word_cnt + CW'(1);
                        if (w_sentinel || w_last_slot) begin
                            r_load_ovf <= !w_sentinel;
                            r_state    <= VERIFY_EN ? S_VERIFY : S_RUN;
                            r_core_rst <= VERIFY_EN;
                        end
                    end
                end
                S_VERIFY: begin
                    r_mem_addr <= w_raddr;
                    r_rd_idx   <= r_rd_idx + CW'(1);
                    if (w_last_rd) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_vld == '0) begin
                        if (r_rchk != r_chk) begin
                            r_verify_err <= 1'b1;
                            r_state      <= S_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_state    <= S_RUN;
                            r_core_rst <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // a halt seen on the final watchdog cycle still counts as a clean stop
                    if (w_halt || w_wd_exp) begin
                        r_timeout  <= !w_halt;
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b1;
                    end else begin
                        r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready    = w_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign verify_err = r_verify_err;
    assign load_ovf   = r_load_ovf;
    assign timeout    = r_timeout;
    assign word_cnt   = r_word_cnt;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_prog_loader_ctl.sv
// Bench for prog_loader_ctl: directed and random images against a
// behavioural model; a monitor scores memory writes and run results.
module tb_prog_loader_ctl;

    localparam int          BASE   = 2048;
    localparam int          DEPTH  = 256;
    localparam int          RD_LAT = 3;
    localparam int          MAXC   = 512;
    localparam int          CW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] HALT   = 32'hFFFF0000;
    localparam logic [31:0] NOP    = 32'h00000013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int wc;
        int cc;
        bit verr;
        bit ovf;
        bit to;
        bit low;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          core_rst;
    logic [31:0]   core_instr = NOP;
    logic          busy;
    logic          done;
    logic          verify_err;
    logic          load_ovf;
    logic          timeout;
    logic [CW-1:0] word_cnt;
    logic [31:0]   cycle_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          halt_h = -1;
    int          rk = 0;
    int          exp_nw = 0;
    bit          corrupt = 1'b0;
    logic [31:0] corrupt_addr = '0;
    bit          seen_low = 1'b0;
    bit          prev_done = 1'b0;
    logic [31:0] img[$];
    wr_t         wq[$];
    res_t        rq[$];
    wr_t         mw;
    res_t        me;

    logic [31:0]          mem [512];
    logic [RD_LAT*32-1:0] pipe = '0;

    prog_loader_ctl #(
        .DW(32), .AW(32), .BASE_ADDR(BASE), .DEPTH(DEPTH),
        .HALT_WORD(HALT), .RD_LAT(RD_LAT), .VERIFY_EN(1'b1),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .core_rst(core_rst),
        .core_instr(core_instr), .busy(busy), .done(done),
        .verify_err(verify_err), .load_ovf(load_ovf),
        .timeout(timeout), .word_cnt(word_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'(((a - 32'(BASE)) >> 2) & 32'd511);
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] v;
        v = mem[widx(a)];
        if (corrupt && a == corrupt_addr) v = v ^ 32'h1;
        return v;
    endfunction

    // memory with RD_LAT-cycle read pipeline
    always @(posedge clk) begin
        if (mem_we) mem[widx(mem_addr)] <= mem_wdata;
        pipe <= {pipe[(RD_LAT-1)*32-1:0], rd_word(mem_addr)};
    end
    assign mem_rdata = pipe[RD_LAT*32-1 -: 32];

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endfunction

    // core model: presents the sentinel on run cycle halt_h
    initial forever begin
        @(negedge clk);
        if (core_rst) begin
            rk = 0;
            core_instr = NOP;
        end else begin
            core_instr = (halt_h >= 0 && rk == halt_h) ? HALT : NOP;
            rk++;
        end
    end

    // monitor
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            seen_low = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (!core_rst) seen_low = 1'b1;
            if (mem_we) begin
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required none",
                             mem_addr, mem_wdata);
                end else begin
                    mw = wq.pop_front();
                    chk("wr_addr", mem_addr, mw.addr);
                    chk("wr_data", mem_wdata, mw.data);
                end
            end
            if (done && !prev_done) begin
                if (rq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, required 0");
                end else begin
                    me = rq.pop_front();
                    chk("word_cnt", word_cnt, me.wc);
                    chk("cycle_cnt", cycle_cnt, me.cc);
                    chk("verify_err", verify_err, me.verr);
                    chk("load_ovf", load_ovf, me.ovf);
                    chk("timeout", timeout, me.to);
                    chk("core_ran", seen_low, me.low);
                    chk("busy_done", busy, 0);
                    chk("core_rst_done", core_rst, 1);
                end
                seen_low = 1'b0;
                n_done++;
            end
            prev_done = done;
        end
    end

    // reference: what the loader should write and report for img
    task automatic model();
        res_t        e;
        wr_t         w;
        bit          hit;
        logic [31:0] c;
        logic [31:0] r;
        logic [31:0] v;
        int          nw;
        hit = 0;
        c = '0;
        r = '0;
        nw = 0;
        for (int j = 0; j < img.size() && j < DEPTH && !hit; j++) begin
            w.addr = 32'(BASE + 4 * j);
            w.data = img[j];
            wq.push_back(w);
            c = c ^ img[j];
            v = img[j];
            if (corrupt && w.addr == corrupt_addr) v = v ^ 32'h1;
            r = r ^ v;
            nw++;
            if (img[j] == HALT) hit = 1;
        end
        e.wc = nw;
        e.ovf = !hit;
        e.verr = (r != c);
        if (e.verr) begin
            e.cc = 0;
            e.to = 0;
            e.low = 0;
        end else begin
            e.low = 1;
            if (halt_h >= 0 && halt_h <= MAXC - 1) begin
                e.cc = halt_h;
                e.to = 0;
            end else begin
                e.cc = MAXC - 1;
                e.to = 1;
            end
        end
        rq.push_back(e);
        exp_nw = nw;
    endtask

    task automatic feed(input int n, input int mode, output int acc);
        int cyc;
        bit v;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 4 * n + 100) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            s_valid = v;
            s_data = img[acc];
            if (v && s_ready) acc++;
            cyc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_case(input string nm, input int mode, input int h,
                            input bit cor, input logic [31:0] caddr,
                            input bit poke);
        int acc;
        int tgt;
        int cyc;
        halt_h = h;
        corrupt = cor;
        corrupt_addr = caddr;
        model();
        tgt = n_done + 1;
        pulse_start();
        feed(img.size(), mode, acc);
        chk({nm, "_accepted"}, acc, exp_nw);
        if (poke) begin
            cyc = 0;
            while (core_rst && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (n_done < tgt && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (n_done < tgt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_wait: got no done, required done within 4000 cycles", nm);
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_s_ready"}, s_ready, 0);
        chk({nm, "_mem_we"}, mem_we, 0);
        chk({nm, "_mem_addr"}, mem_addr, BASE);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_core_rst"}, core_rst, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_verify_err"}, verify_err, 0);
        chk({nm, "_load_ovf"}, load_ovf, 0);
        chk({nm, "_timeout"}, timeout, 0);
        chk({nm, "_word_cnt"}, word_cnt, 0);
        chk({nm, "_cycle_cnt"}, cycle_cnt, 0);
    endtask

    task automatic load_t1();
        img.delete();
        img.push_back(NOP);
        img.push_back(32'h00100093);
        img.push_back(HALT);
    endtask

    initial begin
        int          acc;
        int          len;
        logic [31:0] x;
        wr_t         w;

        #3 rst = 1'b0;
        #1 check_reset("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        load_t1();
        run_case("t1", 0, 10, 0, '0, 0);

        run_case("t2", 0, 10, 1, 32'd2052, 0);

        img.delete();
        for (int j = 0; j < DEPTH + 1; j++) img.push_back(NOP);
        run_case("t3", 0, -1, 0, '0, 0);

        img.delete();
        for (int j = 0; j < DEPTH - 1; j++) img.push_back(NOP);
        img.push_back(HALT);
        run_case("sent_last", 0, 5, 0, '0, 0);

        img.delete();
        for (int j = 0; j < 8; j++) begin
            do x = $urandom; while (x == HALT);
            img.push_back(x);
        end
        img.push_back(HALT);
        run_case("t4", 1, 30, 0, '0, 0);

        img.delete();
        for (int j = 0; j < 10; j++) img.push_back(32'h100 + 32'(j));
        corrupt = 1'b0;
        pulse_start();
        for (int j = 0; j < 5; j++) begin
            w.addr = 32'(BASE + 4 * j);
            w.data = img[j];
            wq.push_back(w);
        end
        feed(5, 0, acc);
        chk("t5_accepted", acc, 5);
        #2 rst = 1'b0;
        #1 check_reset("t5");
        chk("t5_writes_left", wq.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        load_t1();
        run_case("t5_reload", 0, 3, 0, '0, 0);

        run_case("t6", 0, MAXC - 1, 0, '0, 1);

        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 24);
            img.delete();
            for (int j = 0; j < len - 1; j++) begin
                do x = $urandom; while (x == HALT);
                img.push_back(x);
            end
            img.push_back(HALT);
            run_case("rnd", 2, $urandom_range(0, 700),
                     ($urandom_range(0, 2) == 0),
                     32'(BASE + 4 * $urandom_range(0, len - 1)), 0);
        end

        repeat (4) @(negedge clk);
        chk("end_writes_left", wq.size(), 0);
        chk("end_results_left", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader_ctl.md
Name: prog_loader_ctl

Overview:
Synthesizable boot sequencer for single-cycle core benches and FPGA bring-up.
- Accepts a program image on a valid/ready word stream and writes it into memory through a dedicated port, starting at BASE_ADDR.
- Optionally reads the image back and checks an XOR checksum.
- Releases core reset, then watches fetched instructions for the halt sentinel under a cycle watchdog.

Parameters:
DW, 32, data/instruction word width (multiple of 8)
AW, 32, memory address width
BASE_ADDR, 2048, byte address of first program word
DEPTH, 256, max words loadable (terminator included)
HALT_WORD, 32'hFFFF0000, end-of-program sentinel (DW bits)
RD_LAT, 1, memory read latency in cycles (1..4)
VERIFY_EN, 1, 1 = readback checksum pass before run
MAX_CYCLES, 512, run-phase watchdog limit

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begins sequence from IDLE/DONE
s_valid  in  1  image word valid
s_ready  out  1  loader accepts word
s_data  in  DW  image word
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  byte address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid RD_LAT cycles after address
core_rst  out  1  active-high core reset
core_instr  in  DW  instruction currently presented to the core
busy  out  1  sequence in progress
done  out  1  sticky until next start
verify_err  out  1  checksum mismatch (sticky)
load_ovf  out  1  DEPTH reached without sentinel (sticky)
timeout  out  1  watchdog expired (sticky)
word_cnt  out  log2(DEPTH)+1  words written
cycle_cnt  out  32  run-phase cycles elapsed

Behaviour:
- Reset (rst=0, async): state IDLE, s_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_rst=1, busy=0, done=0, all flags 0, word_cnt=0, cycle_cnt=0, checksum=0. Reset mid-sequence aborts immediately; core_rst reasserts that same instant.
- States: IDLE, LOAD, VERIFY, DRAIN, RUN, DONE.
- IDLE/DONE + start: clear counters, flags and checksum; go to LOAD; busy=1. start is ignored in any other state.
- LOAD: s_ready=1 while word_cnt<DEPTH.
  - Each accepted word (s_valid&s_ready) is driven the next cycle: mem_we=1, mem_addr=BASE_ADDR+4*word_cnt (address stride DW/8), mem_wdata=s_data.
  - Same edge: checksum^=s_data, word_cnt++.
  - Accepting HALT_WORD (written like any other word) ends LOAD.
  - Reaching word_cnt==DEPTH without the sentinel sets load_ovf; s_ready drops.
  - Exit goes to VERIFY if VERIFY_EN, else RUN. mem_we returns to 0 the cycle after the last write.
- VERIFY: one read per cycle (mem_we=0), addresses BASE_ADDR upward over word_cnt words.
  - Valid shift register of length RD_LAT tags returns; each returned mem_rdata is XORed into rchk.
  - After the last issue, go to DRAIN. DRAIN waits RD_LAT cycles until all returns are in, then compares.
  - rchk!=checksum sets verify_err and goes to DONE with core held in reset. Otherwise go to RUN.
- RUN: core_rst=0 from the first RUN cycle; cycle_cnt increments every cycle.
  - core_instr==HALT_WORD goes to DONE; cycle_cnt freezes at the value of that cycle.
  - cycle_cnt==MAX_CYCLES-1 without halt sets timeout and goes to DONE.
  - Halt and timeout in the same cycle: halt wins, timeout stays 0.
- DONE: busy=0, done=1, core_rst=1; counters hold their values.
- Empty stream: LOAD waits indefinitely, no watchdog in LOAD.
- A sentinel arriving as word DEPTH-1: accepted, load_ovf stays 0.
- mem_addr wraps modulo 2^AW without error.

Test Plan:
1. Stream 0x00000013, 0x00100093, 0xFFFF0000 -> writes at 2048/2052/2056; word_cnt=3; verify passes; core_rst falls; core_instr=0xFFFF0000 at run cycle 10 -> done=1, cycle_cnt=10, all flags 0.
2. Same image, memory model corrupts word at 2052 (bit 0 flipped) -> verify_err=1, done=1, core_rst never deasserts.
3. 256 words of 0x00000013 with no sentinel -> s_ready low after word 256; load_ovf=1; run proceeds; core_instr never halts -> timeout=1 at cycle_cnt=511.
4. s_valid toggled every other cycle, RD_LAT=3 -> writes contiguous in address with no gaps; checksum matches; verify_err=0.
5. rst pulsed low mid-LOAD after 5 words -> all outputs at reset values asynchronously; new start reloads from 2048 with word_cnt=0.
6. Halt on the same cycle the watchdog expires -> done=1, timeout=0; start pulsed during RUN ignored.
